// File: rtl/i2c_slave_reg.sv
// I2C target exposing a byte-addressed register port with 24Cxx-style write/read access.
// Latency: bus sampled through SYNC_STAGES+1 flops; reg_we/reg_re are one-clk strobes, pointer increments the clk after.
// Backpressure: none; no clock stretching, reg_rdata must be valid 1 clk after reg_addr changes.
//
// Ports: clk/rst (sync, active-high); scl_pad_i/sda_pad_i bus inputs; sda_pad_o (tied 0) and
// sda_padoen_o (active-low enable) drive SDA; reg_addr/reg_wdata/reg_we/reg_re/reg_rdata form the
// local register port; busy is high from our address ACK until STOP, START or master NACK.
// Build option: define I2C_SLAVE_ADDR_2BYTE_EN for a 2-byte (high byte first) word address.
module i2c_slave_reg #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR_S, DEV_ACK, ADDR_HI, ADDR_LO, ADDR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Line conditioning: sync chain plus one history flop per line. Reset to the
  // idle-bus level so leaving reset never fabricates a START.
  // ---------------------------------------------------------------------------
  logic [NSYNC-1:0] scl_sync, sda_sync;
  logic             scl_d, sda_d;
  logic             scl_s, sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NSYNC-2:0], scl_pad_i};
      sda_sync <= {sda_sync[NSYNC-2:0], sda_pad_i};
      scl_d    <= scl_sync[NSYNC-1];
      sda_d    <= sda_sync[NSYNC-1];
    end
  end

  assign scl_s = scl_sync[NSYNC-1];
  assign sda_s = sda_sync[NSYNC-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  sda_d & ~sda_s;
  assign stop_det  =  scl_s & ~sda_d &  sda_s;

  assign sda_pad_o = 1'b0;

  // ---------------------------------------------------------------------------
  // Protocol engine
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [7:0] shift_in;
  logic       rw;
  logic       ack_phase;   // 0: ACK slot not yet driven, 1: ACK slot in progress
  logic       inc_pend;    // pointer increments the clk after a we/re strobe
  logic [7:0] ptr_lo;

  assign shift_in = {sr[6:0], sda_s};

`ifdef I2C_SLAVE_ADDR_2BYTE_EN
  logic [7:0] ptr_hi;
  logic       hi_phase;    // ADDR_ACK just acknowledged the high byte
  assign reg_addr = {ptr_hi, ptr_lo};
`else
  assign reg_addr = {8'h00, ptr_lo};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      sr           <= 8'h00;
      rw           <= 1'b0;
      ack_phase    <= 1'b0;
      inc_pend     <= 1'b0;
      ptr_lo       <= 8'h00;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
      ptr_hi       <= 8'h00;
      hi_phase     <= 1'b0;
`endif
      reg_wdata    <= 8'h00;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      sda_padoen_o <= 1'b1;
      busy         <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;

      if (inc_pend) begin
        inc_pend <= 1'b0;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
        {ptr_hi, ptr_lo} <= {ptr_hi, ptr_lo} + 16'd1;
`else
        ptr_lo <= ptr_lo + 8'd1;
`endif
      end

      if (start_det) begin
        state        <= DEV_ADDR_S;
        bit_cnt      <= 3'd0;
        ack_phase    <= 1'b0;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else if (stop_det) begin
        state        <= IDLE;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          DEV_ADDR_S: if (scl_rise) begin
            sr      <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_in[7:1] == DEV_ADDR) begin
                rw        <= shift_in[0];
                ack_phase <= 1'b0;
                state     <= DEV_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end

          DEV_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_padoen_o <= 1'b0;
              busy         <= 1'b1;
              ack_phase    <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              if (rw) begin
                // First read byte is presented on the same fall that ends the ACK.
                sr           <= reg_rdata;
                reg_re       <= 1'b1;
                inc_pend     <= 1'b1;
                sda_padoen_o <= reg_rdata[7];
                state        <= RDATA;
              end else begin
                sda_padoen_o <= 1'b1;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
                state <= ADDR_HI;
`else
                state <= ADDR_LO;
`endif
              end
            end
          end

`ifdef I2C_SLAVE_ADDR_2BYTE_EN
          ADDR_HI: if (scl_rise) begin
            sr      <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_hi    <= shift_in;
              hi_phase  <= 1'b1;
              ack_phase <= 1'b0;
              state     <= ADDR_ACK;
            end
          end
`endif

          ADDR_LO: if (scl_rise) begin
            sr      <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_lo    <= shift_in;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
              hi_phase  <= 1'b0;
`endif
              ack_phase <= 1'b0;
              state     <= ADDR_ACK;
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_padoen_o <= 1'b0;
              ack_phase    <= 1'b1;
            end else begin
              sda_padoen_o <= 1'b1;
              ack_phase    <= 1'b0;
              bit_cnt      <= 3'd0;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
              state <= hi_phase ? ADDR_LO : WDATA;
`else
              state <= WDATA;
`endif
            end
          end

          WDATA: if (scl_rise) begin
            sr      <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_wdata <= shift_in;
              reg_we    <= 1'b1;
              inc_pend  <= 1'b1;
              ack_phase <= 1'b0;
              state     <= WDATA_ACK;
            end
          end

          WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_padoen_o <= 1'b0;
              ack_phase    <= 1'b1;
            end else begin
              sda_padoen_o <= 1'b1;
              ack_phase    <= 1'b0;
              bit_cnt      <= 3'd0;
              state        <= WDATA;
            end
          end

          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                state     <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              sr           <= {sr[6:0], 1'b0};
              sda_padoen_o <= sr[6];
            end
          end

          // Phase 0: release SDA on the fall after bit 0. Phase 1: the only rise
          // samples the master's ACK; reaching the next fall means it was an ACK.
          RDATA_ACK: begin
            if (scl_rise && ack_phase) begin
              if (sda_s) begin
                sda_padoen_o <= 1'b1;
                busy         <= 1'b0;
                state        <= IDLE;
              end
            end else if (scl_fall) begin
              if (!ack_phase) begin
                sda_padoen_o <= 1'b1;
                ack_phase    <= 1'b1;
              end else begin
                sr           <= reg_rdata;
                reg_re       <= 1'b1;
                inc_pend     <= 1'b1;
                sda_padoen_o <= reg_rdata[7];
                bit_cnt      <= 3'd0;
                ack_phase    <= 1'b0;
                state        <= RDATA;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Directed bench for i2c_slave_reg: bit-banged I2C master on a wired-AND SDA line.
// Timing: SCL period is 20 clks (quarter = 5 clks), SDA changes mid-low-phase.
// Register model: reg_rdata = ~reg_addr[7:0].
module tb_i2c_slave_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_pad_i, sda_pad_i;
  logic        sda_pad_o, sda_padoen_o;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];
  int          low_cnt = 0;

`ifdef I2C_SLAVE_ADDR_2BYTE_EN
  localparam logic [15:0] ADDR_MASK = 16'hFFFF;
`else
  localparam logic [15:0] ADDR_MASK = 16'h00FF;
`endif

  always #5 clk = ~clk;

  assign scl_pad_i = m_scl;
  assign sda_pad_i = m_sda & (sda_padoen_o ? 1'b1 : sda_pad_o);
  assign reg_rdata = ~reg_addr[7:0];

  i2c_slave_reg #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        we_addr_q.push_back(reg_addr);
        we_data_q.push_back(reg_wdata);
      end
      if (reg_re) re_addr_q.push_back(reg_addr);
      if (!sda_padoen_o) low_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- bus master primitives ----------------
  task automatic wq();
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(input logic drive, output logic b);
    m_sda = drive; wq();
    m_scl = 1'b1;  wq();
    b = sda_pad_i; wq();
    m_scl = 1'b0;  wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(1'b1, b);
      d[i] = b;
    end
    read_bit(master_ack, b);
    m_sda = 1'b1;
  endtask

  task automatic send_addr(input logic [15:0] a, output logic nack);
    logic a1, a2;
    a1 = 1'b0;
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
    write_byte(a[15:8], a1);
`endif
    write_byte(a[7:0], a2);
    nack = a1 | a2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sda_padoen_o !== 1'b1) begin tests_failed++; $display("FAIL reset_padoen: got %b required 1", sda_padoen_o); end
    tests_run++;
    if (reg_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h required 0000", reg_addr); end
    tests_run++;
    if ({reg_wdata, reg_we, reg_re, busy} !== 11'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got wdata=%h we=%b re=%b busy=%b required all 0", reg_wdata, reg_we, reg_re, busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    int base;
    base = we_addr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL sw_busy: got %b required 1", busy); end
    send_addr(16'h0012, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    tests_run++;
    if ({a0, a1, a2} !== 3'b000) begin tests_failed++; $display("FAIL sw_acks: got %b required 000", {a0, a1, a2}); end
    tests_run++;
    if (we_addr_q.size() - base !== 1) begin
      tests_failed++; $display("FAIL sw_we_count: got %0d required 1", we_addr_q.size() - base);
    end else begin
      tests_run++;
      if (we_addr_q[base] !== 16'h0012 || we_data_q[base] !== 8'h5A) begin
        tests_failed++; $display("FAIL sw_we: got addr=%h data=%h required addr=0012 data=5a", we_addr_q[base], we_data_q[base]);
      end
    end
    tests_run++;
    if (reg_addr !== 16'h0013) begin tests_failed++; $display("FAIL sw_final_addr: got %h required 0013", reg_addr); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL sw_busy_stop: got %b required 0", busy); end
  endtask

  task automatic test_burst_wrap();
    logic a, nack;
    logic [15:0] exp_a;
    logic [7:0]  exp_d;
    int base;
    base = we_addr_q.size();
    nack = 1'b0;
    i2c_start();
    write_byte(8'hA0, a); nack |= a;
    send_addr(16'h00FE, a); nack |= a;
    for (int i = 1; i <= 3; i++) begin
      exp_d = 8'(i);
      write_byte(exp_d, a); nack |= a;
    end
    i2c_stop();
    tests_run++;
    if (nack !== 1'b0) begin tests_failed++; $display("FAIL bw_acks: got nack=%b required 0", nack); end
    tests_run++;
    if (we_addr_q.size() - base !== 3) begin
      tests_failed++; $display("FAIL bw_we_count: got %0d required 3", we_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_a = (16'h00FE + 16'(i)) & ADDR_MASK;
        exp_d = 8'(i + 1);
        tests_run++;
        if (we_addr_q[base+i] !== exp_a || we_data_q[base+i] !== exp_d) begin
          tests_failed++; $display("FAIL bw_we%0d: got addr=%h data=%h required addr=%h data=%h", i, we_addr_q[base+i], we_data_q[base+i], exp_a, exp_d);
        end
      end
    end
    exp_a = (16'h00FE + 16'd3) & ADDR_MASK;
    tests_run++;
    if (reg_addr !== exp_a) begin tests_failed++; $display("FAIL bw_final_addr: got %h required %h", reg_addr, exp_a); end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    int rbase, wbase;
    rbase = re_addr_q.size();
    wbase = we_addr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    send_addr(16'h0040, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    tests_run++;
    if ({a0, a1, a2} !== 3'b000) begin tests_failed++; $display("FAIL rr_acks: got %b required 000", {a0, a1, a2}); end
    tests_run++;
    if (b0 !== 8'hBF) begin tests_failed++; $display("FAIL rr_byte0: got %h required bf", b0); end
    tests_run++;
    if (b1 !== 8'hBE) begin tests_failed++; $display("FAIL rr_byte1: got %h required be", b1); end
    tests_run++;
    if (busy !== 1'b0 || sda_padoen_o !== 1'b1) begin
      tests_failed++; $display("FAIL rr_nack_release: got busy=%b padoen=%b required busy=0 padoen=1", busy, sda_padoen_o);
    end
    i2c_stop();
    tests_run++;
    if (re_addr_q.size() - rbase !== 2) begin
      tests_failed++; $display("FAIL rr_re_count: got %0d required 2", re_addr_q.size() - rbase);
    end else begin
      tests_run++;
      if (re_addr_q[rbase] !== 16'h0040 || re_addr_q[rbase+1] !== 16'h0041) begin
        tests_failed++; $display("FAIL rr_re_addr: got %h,%h required 0040,0041", re_addr_q[rbase], re_addr_q[rbase+1]);
      end
    end
    tests_run++;
    if (we_addr_q.size() !== wbase) begin tests_failed++; $display("FAIL rr_no_we: got %0d writes required 0", we_addr_q.size() - wbase); end
    tests_run++;
    if (reg_addr !== 16'h0042) begin tests_failed++; $display("FAIL rr_final_addr: got %h required 0042", reg_addr); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    int low0, wbase;
    low0  = low_cnt;
    wbase = we_addr_q.size();
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h12, a1);
    write_byte(8'h34, a2);
    i2c_stop();
    tests_run++;
    if ({a0, a1, a2} !== 3'b111) begin tests_failed++; $display("FAIL mm_nack: got %b required 111", {a0, a1, a2}); end
    tests_run++;
    if (low_cnt !== low0) begin tests_failed++; $display("FAIL mm_sda_driven: got %0d low clks required 0", low_cnt - low0); end
    tests_run++;
    if (we_addr_q.size() !== wbase || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mm_quiet: got writes=%0d busy=%b required writes=0 busy=0", we_addr_q.size() - wbase, busy);
    end
  endtask

  task automatic test_abort_stop();
    logic a0, a1;
    int wbase;
    wbase = we_addr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    send_addr(16'h0020, a1);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop();
    tests_run++;
    if (we_addr_q.size() !== wbase) begin tests_failed++; $display("FAIL ab_stop_we: got %0d writes required 0", we_addr_q.size() - wbase); end
    tests_run++;
    if (reg_addr !== 16'h0020 || busy !== 1'b0 || sda_padoen_o !== 1'b1) begin
      tests_failed++; $display("FAIL ab_stop_state: got addr=%h busy=%b padoen=%b required addr=0020 busy=0 padoen=1", reg_addr, busy, sda_padoen_o);
    end
  endtask

  task automatic test_abort_rst();
    logic a0, a1, a2;
    logic [7:0] dev;
    int wbase;
    // Reset while the target is driving its address ACK.
    dev = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(dev[i]);
    m_sda = 1'b1;
    tests_run++;
    if (sda_padoen_o !== 1'b0) begin tests_failed++; $display("FAIL ar_ack_driven: got padoen=%b required 0", sda_padoen_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (sda_padoen_o !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL ar_release: got padoen=%b busy=%b required padoen=1 busy=0", sda_padoen_o, busy);
    end
    @(negedge clk); rst = 1'b0;
    wq();
    i2c_stop();

    // Reset in the middle of a data byte.
    wbase = we_addr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    send_addr(16'h0031, a1);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    i2c_stop();
    tests_run++;
    if (we_addr_q.size() !== wbase || reg_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL ar_midbyte: got writes=%0d addr=%h required writes=0 addr=0000", we_addr_q.size() - wbase, reg_addr);
    end

    // Normal transaction afterwards.
    i2c_start();
    write_byte(8'hA0, a0);
    send_addr(16'h0055, a1);
    write_byte(8'h66, a2);
    i2c_stop();
    tests_run++;
    if ({a0, a1, a2} !== 3'b000 || we_addr_q.size() - wbase !== 1) begin
      tests_failed++; $display("FAIL ar_recover: got acks=%b writes=%0d required acks=000 writes=1", {a0, a1, a2}, we_addr_q.size() - wbase);
    end else begin
      tests_run++;
      if (we_addr_q[wbase] !== 16'h0055 || we_data_q[wbase] !== 8'h66) begin
        tests_failed++; $display("FAIL ar_recover_we: got addr=%h data=%h required addr=0055 data=66", we_addr_q[wbase], we_data_q[wbase]);
      end
    end
  endtask

`ifdef I2C_SLAVE_ADDR_2BYTE_EN
  task automatic test_two_byte_addr();
    logic a0, a1, a2;
    int wbase;
    wbase = we_addr_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    send_addr(16'h0123, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    tests_run++;
    if ({a0, a1, a2} !== 3'b000 || we_addr_q.size() - wbase !== 1) begin
      tests_failed++; $display("FAIL tb_2byte: got acks=%b writes=%0d required acks=000 writes=1", {a0, a1, a2}, we_addr_q.size() - wbase);
    end else begin
      tests_run++;
      if (we_addr_q[wbase] !== 16'h0123 || we_data_q[wbase] !== 8'h77) begin
        tests_failed++; $display("FAIL tb_2byte_we: got addr=%h data=%h required addr=0123 data=77", we_addr_q[wbase], we_data_q[wbase]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_random_read();
    test_addr_mismatch();
    test_abort_stop();
    test_abort_rst();
`ifdef I2C_SLAVE_ADDR_2BYTE_EN
    test_two_byte_addr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
